// File: rtl/serdes_pkg.sv
// Shared definitions for the bit-serial link: receiver FSM states and the
// bit-counter width used by both the serializer and deserializer sides.
package serdes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SYNC = 1'b1
    } state_t;

    function automatic int cnt_width(input int dw);
        return (dw <= 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/shift_reg.sv
// Parallel-load shift register shifting towards the MSB; load wins over shift.
module ShiftReg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift,
    input  logic         load,
    input  logic         sin,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q_q <= '0;
        else if (load)  q_q <= d;
        else if (shift) q_q <= {q_q[W-2:0], sin};
    end

    assign q = q_q;

endmodule

// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver: sof-aligned word assembly with a
// single-entry valid/ready output register and overrun/frame-error pulses.
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int  DW   = 8,
    parameter type dw_t = logic [DW-1:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sin_valid,
    input  logic sin_data,
    input  logic sin_sof,
    output logic m_valid,
    input  logic m_ready,
    output dw_t  m_data,
    output logic overrun,
    output logic frame_err,
    output logic synced
);

    localparam int CW = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          m_valid_q, overrun_q, frame_err_q;
    dw_t           m_data_q;
    dw_t           acc_q;
    dw_t           word;

    ShiftReg #(.W(DW)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (sin_valid && !sin_sof),
        .load  (sin_valid && sin_sof),
        .sin   (sin_data),
        .d     (dw_t'(sin_data)),
        .q     (acc_q)
    );

    // Truncating cast drops the accumulator MSB, leaving {acc[DW-2:0], sin_data}.
    assign word = dw_t'({acc_q, sin_data});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (m_valid_q && m_ready)
                m_valid_q <= 1'b0;
            if (sin_valid) begin
                case (state_q)
                    IDLE: if (sin_sof) begin
                        state_q <= SYNC;
                        cnt_q   <= CW'(1);
                    end
                    SYNC: if (sin_sof) begin
                        frame_err_q <= (cnt_q != '0);
                        cnt_q       <= CW'(1);
                    end else if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        // A word completing during a handshake refills the register.
                        if (!m_valid_q || m_ready) begin
                            m_data_q  <= word;
                            m_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign synced    = (state_q == SYNC);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (DW=8): vector table for reset and
// basic word reception, hand sequences for overrun, framing and reset cases.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst_n, sin_valid, sin_data, sin_sof, m_ready;
    logic       m_valid, overrun, frame_err, synced;
    logic [7:0] m_data;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    logic fe_first;

    serial_deserializer #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .sin_sof   (sin_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .overrun   (overrun),
        .frame_err (frame_err),
        .synced    (synced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, v, d, sof, rdy;
        logic       mv;
        logic [7:0] md;
        logic       ov, fe, sy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic mv, input logic [7:0] md,
                           input logic ov, input logic fe, input logic sy);
        chk({tag, ".m_valid"},   32'(m_valid),   32'(mv));
        chk({tag, ".m_data"},    32'(m_data),    32'(md));
        chk({tag, ".overrun"},   32'(overrun),   32'(ov));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
        chk({tag, ".synced"},    32'(synced),    32'(sy));
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic d, input logic s, input logic rdy);
        rst_n = r; sin_valid = v; sin_data = d; sin_sof = s; m_ready = rdy;
        @(posedge clk);
        #1;
        if (overrun)   ov_cnt++;
        if (frame_err) fe_cnt++;
    endtask

    task automatic send_word(input logic [7:0] w, input logic sof, input logic rdy, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, w[7-i], (i == 0) && sof, (i == 7) ? rdy_last : rdy);
            if (i == 0) fe_first = frame_err;
        end
    endtask

    initial begin
        logic [7:0] a5;
        int ov0, fe0;
        a5 = 8'hA5;

        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[8+i] = '{1'b1, 1'b1, a5[7-i], (i == 0), 1'b1,
                         (i == 7), (i == 7) ? 8'hA5 : 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};

        // Reset, unsynchronised bits, then a first 8'hA5 word with m_ready=1
        rst_n = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; sin_sof = 1'b0; m_ready = 1'b0;
        #2;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst_n, tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].rdy);
            chk_out($sformatf("vec%0d", i), tbl[i].mv, tbl[i].md, tbl[i].ov, tbl[i].fe, tbl[i].sy);
        end

        // Back-to-back A5, 3C with no consumer: second word is dropped
        ov0 = ov_cnt;
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        chk_out("ovr_first", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        chk_out("ovr_second", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("ovr_after", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);

        // m_ready arrives in the completion cycle of 3C: refill, no overrun
        ov0 = ov_cnt;
        send_word(8'h3C, 1'b0, 1'b0, 1'b1);
        chk_out("hs_refill", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("hs_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("hs_drain", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);

        // Partial word truncated by sof, then 8'hFF
        ov0 = ov_cnt; fe0 = fe_cnt;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fe_none_yet", 32'(fe_cnt - fe0), 32'd0);
        send_word(8'hFF, 1'b1, 1'b1, 1'b1);
        chk("fe_at_sof", 32'(fe_first), 32'd1);
        chk("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("fe_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        chk_out("fe_word", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("fe_drain", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Async reset mid-word with a held output word
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        chk_out("rst_held", 1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, (i == 0), 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        fe0 = fe_cnt;
        send_word(8'h5A, 1'b1, 1'b1, 1'b1);
        chk_out("rst_recover", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk("rst_no_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
